// File: rtl/heap_arb.sv
// heap_arb: arbitrates a heap client (A: alloc/free) and a memory client
// (B: read/write) onto the allocator's single shared port. Each client has a
// one-entry holding slot and a registered response. At most one client issues
// per cycle. The two paths are pipelined: the strobe goes out, the allocator
// result follows one cycle later, and the response register takes it one cycle
// after that.
module heap_arb #(
  parameter int DATA_SZ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  // client A (heap port)
  input  logic               i_a_valid,
  output logic               o_a_ready,
  input  logic [1:0]         i_a_op,
  input  logic [DATA_SZ-1:0] i_a_data,
  input  logic [DATA_SZ-1:0] i_a_addr,
  output logic               o_a_rvalid,
  input  logic               i_a_rready,
  output logic [DATA_SZ-1:0] o_a_raddr,
  // client B (memory port)
  input  logic               i_b_valid,
  output logic               o_b_ready,
  input  logic               i_b_wr,
  input  logic [DATA_SZ-1:0] i_b_addr,
  input  logic [DATA_SZ-1:0] i_b_data,
  output logic               o_b_rvalid,
  input  logic               i_b_rready,
  output logic [DATA_SZ-1:0] o_b_rdata,
  // allocator heap port
  output logic               o_al,
  output logic [DATA_SZ-1:0] o_adata,
  output logic               o_fr,
  output logic [DATA_SZ-1:0] o_faddr,
  input  logic [DATA_SZ-1:0] i_aaddr,
  // allocator memory port
  output logic               o_wr,
  output logic [DATA_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic               o_rd,
  output logic [DATA_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_rdata,
  input  logic               i_full
);

  localparam logic [1:0] OP_ALLOC = 2'b01;

  logic               a_full_q, a_full_d;
  logic [1:0]         a_op_q, a_op_d;
  logic [DATA_SZ-1:0] a_data_q, a_data_d;
  logic [DATA_SZ-1:0] a_addr_q, a_addr_d;
  logic               b_full_q, b_full_d;
  logic               b_wr_q, b_wr_d;
  logic [DATA_SZ-1:0] b_addr_q, b_addr_d;
  logic [DATA_SZ-1:0] b_data_q, b_data_d;
  // pend: a result-bearing request went out last cycle; its result is on the
  // allocator outputs now and is captured at the coming edge.
  logic               a_pend_q, a_pend_d;
  logic               b_pend_q, b_pend_d;
  logic               a_rv_q, a_rv_d;
  logic [DATA_SZ-1:0] a_raddr_q, a_raddr_d;
  logic               b_rv_q, b_rv_d;
  logic [DATA_SZ-1:0] b_rdata_q, b_rdata_d;
  // round-robin pointer: 0 = A has priority, 1 = B has priority
  logic               rr_q, rr_d;

  logic a_acc, b_acc;
  logic a_resp_ok, b_resp_ok;
  logic a_elig, b_elig;
  logic gnt_a, gnt_b;

  assign o_a_ready = !a_full_q && !i_rst;
  assign o_b_ready = !b_full_q && !i_rst;
  assign a_acc     = i_a_valid && o_a_ready && (i_a_op != 2'b00);
  assign b_acc     = i_b_valid && o_b_ready;

  // Eligibility and grant. The response path counts as free if nothing is in
  // flight and the register is empty or draining this edge, so a capture two
  // edges later can never overwrite an unconsumed response.
  always_comb begin
    a_resp_ok = !a_pend_q && (!a_rv_q || i_a_rready);
    b_resp_ok = !b_pend_q && (!b_rv_q || i_b_rready);
    a_elig    = a_full_q && (!a_op_q[0] || a_resp_ok)
                && !((a_op_q == OP_ALLOC) && i_full);
    b_elig    = b_full_q && (b_wr_q || b_resp_ok);
    gnt_a     = !i_rst && a_elig && (!b_elig || !rr_q);
    gnt_b     = !i_rst && b_elig && !gnt_a;
  end

  // Allocator strobes come straight from the granted slot; data always follows the slots.
  always_comb begin
    o_al    = gnt_a && a_op_q[0];
    o_fr    = gnt_a && a_op_q[1];
    o_adata = a_data_q;
    o_faddr = a_addr_q;
    o_wr    = gnt_b && b_wr_q;
    o_rd    = gnt_b && !b_wr_q;
    o_waddr = b_addr_q;
    o_raddr = b_addr_q;
    o_wdata = b_data_q;
  end

  assign o_a_rvalid = a_rv_q;
  assign o_a_raddr  = a_raddr_q;
  assign o_b_rvalid = b_rv_q;
  assign o_b_rdata  = b_rdata_q;

  // Next state for slots, in-flight flags, response registers and pointer.
  always_comb begin
    a_full_d  = a_full_q;
    a_op_d    = a_op_q;
    a_data_d  = a_data_q;
    a_addr_d  = a_addr_q;
    b_full_d  = b_full_q;
    b_wr_d    = b_wr_q;
    b_addr_d  = b_addr_q;
    b_data_d  = b_data_q;
    a_rv_d    = a_rv_q;
    a_raddr_d = a_raddr_q;
    b_rv_d    = b_rv_q;
    b_rdata_d = b_rdata_q;
    rr_d      = rr_q;
    a_pend_d  = o_al;
    b_pend_d  = o_rd;

    if (gnt_a) a_full_d = 1'b0;
    if (a_acc) begin
      a_full_d = 1'b1;
      a_op_d   = i_a_op;
      a_data_d = i_a_data;
      a_addr_d = i_a_addr;
    end
    if (gnt_b) b_full_d = 1'b0;
    if (b_acc) begin
      b_full_d = 1'b1;
      b_wr_d   = i_b_wr;
      b_addr_d = i_b_addr;
      b_data_d = i_b_data;
    end

    // a capture on the drain edge overrides the clear, keeping rvalid high
    if (a_rv_q && i_a_rready) a_rv_d = 1'b0;
    if (a_pend_q) begin
      a_rv_d    = 1'b1;
      a_raddr_d = i_aaddr;
    end
    if (b_rv_q && i_b_rready) b_rv_d = 1'b0;
    if (b_pend_q) begin
      b_rv_d    = 1'b1;
      b_rdata_d = i_rdata;
    end

    if (a_elig && b_elig && !i_rst) rr_d = !rr_q;
  end

  // State registers with synchronous reset; reset drops all in-flight work.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_full_q  <= 1'b0;
      a_op_q    <= 2'b00;
      a_data_q  <= '0;
      a_addr_q  <= '0;
      b_full_q  <= 1'b0;
      b_wr_q    <= 1'b0;
      b_addr_q  <= '0;
      b_data_q  <= '0;
      a_pend_q  <= 1'b0;
      b_pend_q  <= 1'b0;
      a_rv_q    <= 1'b0;
      a_raddr_q <= '0;
      b_rv_q    <= 1'b0;
      b_rdata_q <= '0;
      rr_q      <= 1'b0;
    end else begin
      a_full_q  <= a_full_d;
      a_op_q    <= a_op_d;
      a_data_q  <= a_data_d;
      a_addr_q  <= a_addr_d;
      b_full_q  <= b_full_d;
      b_wr_q    <= b_wr_d;
      b_addr_q  <= b_addr_d;
      b_data_q  <= b_data_d;
      a_pend_q  <= a_pend_d;
      b_pend_q  <= b_pend_d;
      a_rv_q    <= a_rv_d;
      a_raddr_q <= a_raddr_d;
      b_rv_q    <= b_rv_d;
      b_rdata_q <= b_rdata_d;
      rr_q      <= rr_d;
    end
  end

endmodule

// File: tb/tb_heap_arb.sv
// Bench for heap_arb: a small allocator model supplies addresses and memory
// data; expected responses are queued at accept time and checked by a monitor.
module tb_heap_arb;
  localparam int W = 16;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_a_valid, o_a_ready, o_a_rvalid, i_a_rready;
  logic [1:0]   i_a_op;
  logic [W-1:0] i_a_data, i_a_addr, o_a_raddr;
  logic         i_b_valid, o_b_ready, i_b_wr, o_b_rvalid, i_b_rready;
  logic [W-1:0] i_b_addr, i_b_data, o_b_rdata;
  logic         o_al, o_fr, o_wr, o_rd, i_full;
  logic [W-1:0] o_adata, o_faddr, o_waddr, o_wdata, o_raddr;
  logic [W-1:0] i_aaddr = '0;
  logic [W-1:0] i_rdata = '0;

  heap_arb #(.DATA_SZ(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_op(i_a_op),
    .i_a_data(i_a_data), .i_a_addr(i_a_addr), .o_a_rvalid(o_a_rvalid),
    .i_a_rready(i_a_rready), .o_a_raddr(o_a_raddr),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_wr(i_b_wr),
    .i_b_addr(i_b_addr), .i_b_data(i_b_data), .o_b_rvalid(o_b_rvalid),
    .i_b_rready(i_b_rready), .o_b_rdata(o_b_rdata),
    .o_al(o_al), .o_adata(o_adata), .o_fr(o_fr), .o_faddr(o_faddr),
    .i_aaddr(i_aaddr),
    .o_wr(o_wr), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_rd(o_rd),
    .o_raddr(o_raddr), .i_rdata(i_rdata), .i_full(i_full)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] exp_next = 16'h5000;
  logic [W-1:0] mdl_ptr  = 16'h5000;
  logic [W-1:0] mem [256];
  logic [W-1:0] mon_e;

  // allocator model: hands out sequential addresses, one-cycle result latency
  always @(posedge i_clk) begin
    if (o_al) begin
      i_aaddr <= mdl_ptr;
      mdl_ptr <= mdl_ptr + 16'd1;
    end
    if (o_wr) mem[o_waddr[7:0]] <= o_wdata;
    if (o_rd) i_rdata <= mem[o_raddr[7:0]];
  end

  // response scoreboard and per-cycle strobe exclusivity
  always @(negedge i_clk) begin
    if (o_a_rvalid && i_a_rready) begin
      n_vec++;
      if (exp_a.size() == 0) begin
        n_err++;
        $display("FAIL a_resp_unexpected got=%h want=none", o_a_raddr);
      end else begin
        mon_e = exp_a.pop_front();
        if (o_a_raddr !== mon_e) begin
          n_err++;
          $display("FAIL a_resp_addr got=%h want=%h", o_a_raddr, mon_e);
        end
      end
    end
    if (o_b_rvalid && i_b_rready) begin
      n_vec++;
      if (exp_b.size() == 0) begin
        n_err++;
        $display("FAIL b_resp_unexpected got=%h want=none", o_b_rdata);
      end else begin
        mon_e = exp_b.pop_front();
        if (o_b_rdata !== mon_e) begin
          n_err++;
          $display("FAIL b_resp_data got=%h want=%h", o_b_rdata, mon_e);
        end
      end
    end
    n_vec++;
    if ((o_al || o_fr) && (o_wr || o_rd)) begin
      n_err++;
      $display("FAIL one_group al=%b fr=%b wr=%b rd=%b want=single", o_al, o_fr, o_wr, o_rd);
    end
  end

  // drive one A request until accepted; returns at mid-cycle of the cycle after accept
  task automatic send_a(input logic [1:0] op, input logic [W-1:0] d, input logic [W-1:0] a);
    int t = 0;
    @(posedge i_clk); #1;
    i_a_valid = 1'b1; i_a_op = op; i_a_data = d; i_a_addr = a;
    @(negedge i_clk);
    while (!o_a_ready && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    n_vec++;
    if (o_a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL a_accept_timeout ready=%b want=1", o_a_ready);
    end else if (op[0]) begin
      exp_a.push_back(exp_next);
      exp_next = exp_next + 16'd1;
    end
    @(posedge i_clk); #1;
    i_a_valid = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic send_b(input logic wr, input logic [W-1:0] a, input logic [W-1:0] d,
                        input logic [W-1:0] rexp);
    int t = 0;
    @(posedge i_clk); #1;
    i_b_valid = 1'b1; i_b_wr = wr; i_b_addr = a; i_b_data = d;
    @(negedge i_clk);
    while (!o_b_ready && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    n_vec++;
    if (o_b_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b_accept_timeout ready=%b want=1", o_b_ready);
    end else if (!wr) begin
      exp_b.push_back(rexp);
    end
    @(posedge i_clk); #1;
    i_b_valid = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_vec++; if (o_a_ready !== 1'b0) begin n_err++; $display("FAIL rst_a_ready got=%b want=0", o_a_ready); end
    n_vec++; if (o_b_ready !== 1'b0) begin n_err++; $display("FAIL rst_b_ready got=%b want=0", o_b_ready); end
    n_vec++; if ({o_a_rvalid, o_b_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid got=%b want=00", {o_a_rvalid, o_b_rvalid}); end
    n_vec++; if ({o_al, o_fr, o_wr, o_rd} !== 4'b0) begin n_err++; $display("FAIL rst_strobes got=%b want=0000", {o_al, o_fr, o_wr, o_rd}); end
    n_vec++; if (o_a_raddr !== 16'h0000) begin n_err++; $display("FAIL rst_a_raddr got=%h want=0000", o_a_raddr); end
    n_vec++; if (o_b_rdata !== 16'h0000) begin n_err++; $display("FAIL rst_b_rdata got=%h want=0000", o_b_rdata); end
    n_vec++; if (o_adata !== 16'h0000) begin n_err++; $display("FAIL rst_adata got=%h want=0000", o_adata); end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    n_vec++; if ({o_a_ready, o_b_ready} !== 2'b11) begin n_err++; $display("FAIL rst_release_ready got=%b want=11", {o_a_ready, o_b_ready}); end
  endtask

  task automatic test_alloc();
    for (int k = 0; k < 2; k++) begin
      send_a(2'b01, 16'h8005, 16'h0000);
      n_vec++; if (o_al !== 1'b1) begin n_err++; $display("FAIL alloc_strobe k=%0d got=%b want=1", k, o_al); end
      n_vec++; if (o_adata !== 16'h8005) begin n_err++; $display("FAIL alloc_adata got=%h want=8005", o_adata); end
      n_vec++; if (o_fr !== 1'b0) begin n_err++; $display("FAIL alloc_fr got=%b want=0", o_fr); end
      @(negedge i_clk);
      n_vec++; if ({o_al, o_a_rvalid} !== 2'b00) begin n_err++; $display("FAIL alloc_pulse al_rvalid=%b want=00", {o_al, o_a_rvalid}); end
      @(negedge i_clk);
      n_vec++; if (o_a_rvalid !== 1'b1) begin n_err++; $display("FAIL alloc_rvalid_time got=%b want=1", o_a_rvalid); end
      n_vec++; if (o_a_raddr !== 16'h5000 + 16'(k)) begin n_err++; $display("FAIL alloc_raddr got=%h want=%h", o_a_raddr, 16'h5000 + 16'(k)); end
      @(negedge i_clk);
    end
    // illegal op is dropped at accept: slot stays empty, nothing issues
    send_a(2'b00, 16'hDEAD, 16'hBEEF);
    for (int k = 0; k < 3; k++) begin
      n_vec++; if ({o_al, o_fr, o_a_ready} !== 3'b001) begin n_err++; $display("FAIL op00_drop al_fr_ready=%b want=001", {o_al, o_fr, o_a_ready}); end
      @(negedge i_clk);
    end
  endtask

  task automatic test_write_read();
    send_b(1'b1, 16'h5000, 16'h1234, 16'h0000);
    n_vec++; if ({o_wr, o_rd} !== 2'b10) begin n_err++; $display("FAIL wr_strobe wr_rd=%b want=10", {o_wr, o_rd}); end
    n_vec++; if ({o_waddr, o_wdata} !== {16'h5000, 16'h1234}) begin n_err++; $display("FAIL wr_data got=%h/%h want=5000/1234", o_waddr, o_wdata); end
    send_b(1'b0, 16'h5000, 16'h0000, 16'h1234);
    n_vec++; if ({o_wr, o_rd} !== 2'b01) begin n_err++; $display("FAIL rd_strobe wr_rd=%b want=01", {o_wr, o_rd}); end
    n_vec++; if (o_raddr !== 16'h5000) begin n_err++; $display("FAIL rd_addr got=%h want=5000", o_raddr); end
    repeat (2) @(negedge i_clk);
    n_vec++; if ({o_b_rvalid, o_b_rdata} !== {1'b1, 16'h1234}) begin n_err++; $display("FAIL rd_resp got=%b/%h want=1/1234", o_b_rvalid, o_b_rdata); end
    @(negedge i_clk);
  endtask

  task automatic test_back_to_back();
    int last = 0, cur, want, ga = 0, acc = 0;
    for (int k = 0; k < 22; k++) begin
      @(posedge i_clk); #1;
      if (k < 14) begin
        i_a_valid = 1'b1; i_a_op = 2'b01; i_a_data = 16'h7000 + 16'(k);
        i_b_valid = 1'b1; i_b_wr = 1'b1; i_b_addr = 16'h5010 + 16'(k); i_b_data = 16'h0100 + 16'(k);
      end else begin
        i_a_valid = 1'b0; i_b_valid = 1'b0;
      end
      @(negedge i_clk);
      if (i_a_valid && o_a_ready) begin
        exp_a.push_back(exp_next);
        exp_next = exp_next + 16'd1;
        acc++;
      end
      cur = (o_al || o_fr) ? 1 : ((o_wr || o_rd) ? 2 : 0);
      if (cur != 0) begin
        want = (last == 0) ? 1 : 3 - last;
        n_vec++; if (cur != want) begin n_err++; $display("FAIL rr_order cycle=%0d got=%0d want=%0d", k, cur, want); end
        if (cur == 1) ga++;
        last = cur;
      end
    end
    n_vec++; if (ga != acc || ga < 6) begin n_err++; $display("FAIL rr_a_grants got=%0d want=%0d(>=6)", ga, acc); end
  endtask

  task automatic test_full();
    i_full = 1'b1;
    send_a(2'b11, 16'hAAAA, 16'h5000);
    n_vec++; if ({o_al, o_fr} !== 2'b11) begin n_err++; $display("FAIL full_op11 al_fr=%b want=11", {o_al, o_fr}); end
    n_vec++; if (o_faddr !== 16'h5000) begin n_err++; $display("FAIL full_faddr got=%h want=5000", o_faddr); end
    repeat (3) @(negedge i_clk);
    send_a(2'b01, 16'h0042, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (o_al !== 1'b0) begin n_err++; $display("FAIL full_block cycle=%0d al=%b want=0", k, o_al); end
      @(negedge i_clk);
    end
    @(posedge i_clk); #1;
    i_full = 1'b0;
    @(negedge i_clk);
    n_vec++; if (o_al !== 1'b1) begin n_err++; $display("FAIL full_resume al=%b want=1", o_al); end
    repeat (4) @(negedge i_clk);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] first;
    i_a_rready = 1'b0;
    first = exp_next;
    send_a(2'b01, 16'h0001, 16'h0000);
    send_a(2'b01, 16'h0002, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (o_al !== 1'b0) begin n_err++; $display("FAIL bp_hold_issue cycle=%0d al=%b want=0", k, o_al); end
      n_vec++; if ({o_a_rvalid, o_a_raddr} !== {1'b1, first}) begin n_err++; $display("FAIL bp_stable got=%b/%h want=1/%h", o_a_rvalid, o_a_raddr, first); end
      @(negedge i_clk);
    end
    @(posedge i_clk); #1;
    i_a_rready = 1'b1;
    @(negedge i_clk);
    n_vec++; if (o_al !== 1'b1) begin n_err++; $display("FAIL bp_release al=%b want=1", o_al); end
    repeat (5) @(negedge i_clk);
  endtask

  task automatic test_reset_mid();
    i_a_rready = 1'b0; i_b_rready = 1'b0;
    send_a(2'b01, 16'h0011, 16'h0000);
    send_a(2'b01, 16'h0022, 16'h0000);
    send_b(1'b0, 16'h5000, 16'h0000, 16'h1234);
    send_b(1'b0, 16'h5000, 16'h0000, 16'h1234);
    repeat (3) @(negedge i_clk);
    n_vec++; if ({o_a_rvalid, o_b_rvalid, o_a_ready, o_b_ready} !== 4'b1100) begin n_err++; $display("FAIL mid_fill got=%b want=1100", {o_a_rvalid, o_b_rvalid, o_a_ready, o_b_ready}); end
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    n_vec++; if ({o_a_ready, o_b_ready} !== 2'b00) begin n_err++; $display("FAIL mid_rst_ready got=%b want=00", {o_a_ready, o_b_ready}); end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    n_vec++; if ({o_a_rvalid, o_b_rvalid} !== 2'b00) begin n_err++; $display("FAIL mid_rvalid got=%b want=00", {o_a_rvalid, o_b_rvalid}); end
    n_vec++; if ({o_al, o_fr, o_wr, o_rd} !== 4'b0) begin n_err++; $display("FAIL mid_strobes got=%b want=0000", {o_al, o_fr, o_wr, o_rd}); end
    n_vec++; if ({o_a_ready, o_b_ready} !== 2'b11) begin n_err++; $display("FAIL mid_ready got=%b want=11", {o_a_ready, o_b_ready}); end
    // both queued responses are discarded; the second alloc never reached the allocator
    exp_a.delete();
    exp_b.delete();
    exp_next = exp_next - 16'd1;
    i_a_rready = 1'b1; i_b_rready = 1'b1;
    send_a(2'b01, 16'h0033, 16'h0000);
    repeat (4) @(negedge i_clk);
  endtask

  initial begin
    i_rst = 1'b1;
    i_a_valid = 1'b0; i_a_op = 2'b00; i_a_data = '0; i_a_addr = '0; i_a_rready = 1'b1;
    i_b_valid = 1'b0; i_b_wr = 1'b0; i_b_addr = '0; i_b_data = '0; i_b_rready = 1'b1;
    i_full = 1'b0;
    test_reset();
    test_alloc();
    test_write_read();
    test_back_to_back();
    test_full();
    test_backpressure();
    test_reset_mid();
    n_vec++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_err++;
      $display("FAIL leftover_responses got=%0d/%0d want=0/0", exp_a.size(), exp_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t want=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
